// File: rtl/fnd_pkg.sv
// fnd_pkg: constants and types shared by the FND scan controller.
//   SEG_0 .. SEG_9, SEG_BLANK : 7-bit segment patterns, active-low, bit order gfedcba
//   fnd_state_e               : scan FSM state (blank interval / digit drive)
package fnd_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } fnd_state_e;

endpackage

// File: rtl/fnd_dec.sv
// fnd_dec: combinational BCD to 7-segment decoder.
//   bcd : 4-bit code; 0..9 map to digit glyphs, 10..15 map to all segments off
//   seg : segment pattern, active-low, bit order gfedcba
module fnd_dec
   import fnd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits
// sharing one segment bus. Each digit slot is SCAN_DIV cycles: BLANK_CYC cycles with
// every digit off (anti-ghosting), then the digit is driven. New values are committed
// to the display only at frame boundaries so a half-updated number is never shown.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bcd_in      : packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   dp_in       : decimal point request per digit, active-high
//   load        : one-cycle strobe capturing bcd_in/dp_in into the pending register
//   seg         : segment drive, active-low, gfedcba
//   dp_n        : decimal point drive, active-low
//   dig_sel_n   : digit enable, active-low, one-hot or all ones
//   frame_done  : one-cycle pulse when the last slot of a frame ends (commit cycle)
//
// Optional feature: define FND_LZB_EN to blank leading zeros (digit 0 and digits
// with a decimal point request are never blanked).
//
// Handshake: load is a plain strobe with no ready; it is accepted on every cycle it is
// high, and the last load before a commit is the one displayed.
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   dig_sel_n,
   output logic                    frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

   fnd_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   dig_sel_n_q, dig_sel_n_d;
   logic                    frame_done_q, frame_done_d;

   logic                    frame_last;
   logic [3:0]              cur_code;
   logic                    cur_dp;
   logic [3:0]              dec_in;
   logic [6:0]              dec_seg;

   // Slot sequencer: counter runs 0..SCAN_DIV-1 every slot; the FSM only decides
   // whether the current digit is lit.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      frame_last = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNT_BLANK_LAST) begin
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_BLANK;
               if (idx_q == IDX_LAST) begin
                  idx_d      = '0;
                  frame_last = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // Pending/display registers. The commit happens in the cycle frame_done is high;
   // a load in that same cycle bypasses the pending register so it is not lost.
   always_comb begin
      pend_bcd_d = pend_bcd_q;
      pend_dp_d  = pend_dp_q;
      disp_bcd_d = disp_bcd_q;
      disp_dp_d  = disp_dp_q;
      if (load) begin
         pend_bcd_d = bcd_in;
         pend_dp_d  = dp_in;
      end
      if (frame_done_q) begin
         if (load) begin
            disp_bcd_d = bcd_in;
            disp_dp_d  = dp_in;
         end else begin
            disp_bcd_d = pend_bcd_q;
            disp_dp_d  = pend_dp_q;
         end
      end
   end

   // Digit mux feeding the single shared decoder.
   always_comb begin
      cur_code = 4'hF;
      cur_dp   = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_code = disp_bcd_q[4*k +: 4];
            cur_dp   = disp_dp_q[k];
         end
      end
   end

`ifdef FND_LZB_EN
   logic [NUM_DIGITS-1:0] lzb_mask;
   logic                  cur_lzb;

   // Walk from the most significant digit down; a zero digit stays blank while
   // everything above it is zero or an undisplayable code.
   always_comb begin
      logic lead;
      lead     = 1'b1;
      lzb_mask = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (lead && (disp_bcd_q[4*k +: 4] == 4'd0) && !disp_dp_q[k]) begin
            lzb_mask[k] = 1'b1;
         end
         if ((disp_bcd_q[4*k +: 4] != 4'd0) && (disp_bcd_q[4*k +: 4] < 4'd10)) begin
            lead = 1'b0;
         end
      end
   end

   always_comb begin
      cur_lzb = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_lzb = lzb_mask[k];
         end
      end
   end

   assign dec_in = cur_lzb ? 4'hF : cur_code;
`else
   assign dec_in = cur_code;
`endif

   fnd_dec u_dec (
      .bcd (dec_in),
      .seg (dec_seg)
   );

   // Output registers: segments and selects update on the same edge.
   always_comb begin
      seg_d        = SEG_BLANK;
      dp_n_d       = 1'b1;
      dig_sel_n_d  = '1;
      frame_done_d = frame_last;
      if (state_q == ST_DRIVE) begin
         seg_d  = dec_seg;
         dp_n_d = ~cur_dp;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_sel_n_d[k] = (idx_q != IDX_W'(k));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_bcd_q   <= '1;
         pend_dp_q    <= '0;
         disp_bcd_q   <= '1;
         disp_dp_q    <= '0;
         seg_q        <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         dig_sel_n_q  <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_bcd_q   <= pend_bcd_d;
         pend_dp_q    <= pend_dp_d;
         disp_bcd_q   <= disp_bcd_d;
         disp_dp_q    <= disp_dp_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
         dig_sel_n_q  <= dig_sel_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign dig_sel_n  = dig_sel_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment (FND) digits that share one segment bus. It latches a packed BCD word and drives one digit at a time through a shared BCD-to-segment decoder. Each digit slot starts with an anti-ghosting blank interval. New values are committed only at frame boundaries, so a partially updated number is never displayed. It sits between the application counters/registers and the board's FND pins.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range is 2 or more.
- SCAN_DIV, 50000: clock cycles per digit slot, blank interval included.
- BLANK_CYC, 16: cycles per slot with all digits off; must satisfy 1 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit k is bcd_in[4k+3:4k], and digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- load  in  1  single-cycle strobe that captures bcd_in and dp_in.
- seg  out  7  segment drive, active-low, bit order gfedcba.
- dp_n  out  1  decimal point drive, active-low.
- dig_sel_n  out  NUM_DIGITS  digit enable, active-low, one-hot or all-ones.
- frame_done  out  1  one-cycle pulse when the last digit slot of a frame ends.

## Operation
- **Registers.**
  - Pending register: NUM_DIGITS×(4+1) bits.
  - Display register: same width.
  - Digit index: ⌈log2 NUM_DIGITS⌉ bits.
  - Slot counter: ⌈log2 SCAN_DIV⌉ bits.
  - FSM state.
- **load.** On load, bcd_in and dp_in are written to the pending register. If several loads occur within one frame, the last one wins.
- **Commit.** The pending register is copied to the display register at commit, i.e. the cycle frame_done is asserted.
  - If load and commit fall on the same cycle, bcd_in and dp_in go straight to the display register, and to the pending register as well.
- **FSM states:**
  - BLANK: dig_sel_n is all ones, seg = 7'b1111111, dp_n = 1. Lasts BLANK_CYC cycles, then goes to DRIVE.
  - DRIVE: dig_sel_n[idx] = 0, seg = decode(display digit idx), dp_n = ~dp(idx). Lasts SCAN_DIV − BLANK_CYC cycles, then:
    - idx advances by 1;
    - when idx = NUM_DIGITS−1, idx wraps to 0, frame_done pulses and the commit happens;
    - the FSM returns to BLANK.
- **Decode table:**
  - Codes 0–9 map to the standard patterns: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Codes 10–15 map to blank (1111111).
  - The decoder is fully specified; there are no latches.
- **Slot counter.** Counts from 0 to SCAN_DIV−1 and wraps. The BLANK→DRIVE transition happens at count BLANK_CYC−1, and the slot ends at SCAN_DIV−1.

## Timing
- **Reset values.** seg = 7'h7F, dp_n = 1, dig_sel_n = all ones, frame_done = 0, state BLANK, idx 0, counter 0. Both the display and pending registers reset to BCD 4'hF (blank) with dp = 0.
- **Output registers.** All outputs are registered, so they change one cycle after the state/counter edge that causes them. Segment and select outputs change on the same edge, so no glitching combination is ever driven.
- **Scan cadence.**
  - After rst_n deasserts: BLANK_CYC blank cycles, then digit 0 is driven.
  - Each slot is exactly SCAN_DIV cycles.
  - A frame is NUM_DIGITS × SCAN_DIV cycles.
- **Load-to-display latency.** A load is displayed starting with the digit-0 slot of the next frame, which at most is one frame plus BLANK_CYC+1 cycles later.
- **Reset mid-operation.** Asserting rst_n mid-slot returns all outputs to their reset values immediately (asynchronous) and discards pending data.

## Configuration
- **FND_LZB_EN** defined: leading-zero blanking is enabled.
  - At display time, a digit k ≥ 1 whose code is 0 is blanked if every more-significant digit is 0 or blank.
  - Digit 0 is never blanked.
  - A digit whose dp request is set is never blanked.
- **FND_LZB_EN** undefined: zeros are always shown. There is no extra logic.

## Structure
- **Package fnd_pkg:**
  - segment constants SEG_0 … SEG_9 and SEG_BLANK (7-bit, active-low gfedcba);
  - FSM state enum {ST_BLANK, ST_DRIVE}.
- **Sub-module fnd_dec:** combinational 4-bit BCD to 7-bit segment decoder following the table above; instantiated once and fed by the idx mux.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- **Reset:** hold rst_n low 5 cycles → seg=7F, dp_n=1, dig_sel_n=4'b1111, frame_done=0; after release, 2 blank cycles, then dig_sel_n=4'b1110.
- **Basic scan:** load bcd_in=16'h1234 before the first frame_done → next frame shows:
  - dig_sel_n 1110 with seg 0011001;
  - 1101 with 0110000;
  - 1011 with 0100100;
  - 0111 with 1111001;
  - each digit for 6 cycles after 2 blank cycles;
  - frame_done every 32 cycles.
- **Tearing protection:** load 16'h5678 mid-frame → the current frame still shows 1234, the next frame shows 5678; load coincident with frame_done shows the new value in the immediately following frame.
- **Invalid codes:** load 16'hABCF with dp_in=4'b0001 → digits 3..1 show seg=1111111; digit 0 shows seg=1111111 with dp_n=0.
- **FND_LZB_EN:**
  - load 16'h0042: with the macro, digits 3 and 2 are blank; without it, both show 1000000.
  - load 16'h0000: with the macro, only digit 0 shows 0.
- **Reset mid-slot:** pulse rst_n low during DRIVE of digit 2 → outputs go to reset values the same cycle, and the scan restarts at digit 0 showing blank.
